// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared types and signed range helpers for alu_mc
package alu_mc_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULT = 2'd2,
    DIV  = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV_BUSY,
    HOLD
  } alu_state_e;

  // Representable range of a w-bit two's-complement value (w <= 63)
  function automatic longint signed_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint signed_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - iterative restoring divider on unsigned magnitudes
// Quotient is valid and held from the done cycle until the next start.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic             running;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Borrow out of the trial subtraction means the partial remainder is restored
  always_comb begin
    shifted = {rem, quotient[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  assign done = running && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      count    <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (start) begin
      running  <= 1'b1;
      count    <= CW'(WIDTH);
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (running) begin
      if (count != '0) begin
        count <= count - CW'(1);
        if (trial[WIDTH]) begin
          rem      <= shifted[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], 1'b0};
        end else begin
          rem      <= trial[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], 1'b1};
        end
      end else begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle signed ALU with valid/ready handshakes
// Single-cycle ops pass through a capture stage; DIV runs on alu_div_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_e          opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam logic signed [2*WIDTH-1:0] PROD_MAX = (2*WIDTH)'(signed_max(WIDTH));
  localparam logic signed [2*WIDTH-1:0] PROD_MIN = (2*WIDTH)'(signed_min(WIDTH));

  alu_state_e state, state_next;

  logic             accept, out_free, div_start, div_done, div_load, pend_load;
  logic             pend_valid, div_neg;
  opcode_e          pend_op;
  logic [WIDTH-1:0] pend_a, pend_b;
  logic [WIDTH-1:0] mag_a, mag_b, quotient;
  logic [WIDTH-1:0] sum, diff, alu_res, div_res;
  logic             alu_ovf, alu_dbz, div_ovf;
  logic signed [2*WIDTH-1:0] prod;

  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode == DIV) && (operand_b != '0);
  assign pend_load = pend_valid && out_free;
  assign mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (div_start) state_next = DIV_BUSY;
      DIV_BUSY: if (div_done) state_next = out_free ? IDLE : HOLD;
      HOLD:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    div_load = 1'b0;
    case (state)
      IDLE:     in_ready = !rst && out_free;
      DIV_BUSY: div_load = div_done && out_free;
      HOLD:     div_load = out_ready;
      default:  ;
    endcase
  end

  // A pending single-cycle op always drains on the accepting edge, so it never coexists with a DIV
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_op    <= ADD;
      pend_a     <= '0;
      pend_b     <= '0;
      div_neg    <= 1'b0;
    end else if (accept) begin
      pend_valid <= !div_start;
      pend_op    <= opcode;
      pend_a     <= operand_a;
      pend_b     <= operand_b;
      div_neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
    end else if (pend_load) begin
      pend_valid <= 1'b0;
    end
  end

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    sum     = pend_a + pend_b;
    diff    = pend_a - pend_b;
    prod    = $signed({{WIDTH{pend_a[WIDTH-1]}}, pend_a} * {{WIDTH{pend_b[WIDTH-1]}}, pend_b});
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dbz = 1'b0;
    case (pend_op)
      ADD: begin
        alu_res = sum;
        alu_ovf = (pend_a[WIDTH-1] == pend_b[WIDTH-1]) && (sum[WIDTH-1] != pend_a[WIDTH-1]);
      end
      SUB: begin
        alu_res = diff;
        alu_ovf = (pend_a[WIDTH-1] != pend_b[WIDTH-1]) && (diff[WIDTH-1] != pend_a[WIDTH-1]);
      end
      MULT: begin
        alu_res = prod[WIDTH-1:0];
        alu_ovf = (prod > PROD_MAX) || (prod < PROD_MIN);
      end
      DIV:     alu_dbz = 1'b1;
      default: ;
    endcase
    // Only MIN / -1 yields a positive quotient magnitude with the top bit set
    div_res = div_neg ? -quotient : quotient;
    div_ovf = !div_neg && quotient[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (pend_load) begin
      out_valid   <= 1'b1;
      result      <= alu_res;
      overflow    <= alu_ovf;
      div_by_zero <= alu_dbz;
    end else if (div_load) begin
      out_valid   <= 1'b1;
      result      <= div_res;
      overflow    <= div_ovf;
      div_by_zero <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle signed ALU with valid/ready handshakes on both sides. ADD, SUB and MULT complete in one cycle. DIV runs on an iterative restoring divider. All results are registered with overflow and divide-by-zero flags. It is the next generation of the team's sequential byte ALU and is intended to sit between a stimulus/command source and a result consumer that may stall.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 4); two's-complement signed

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  command valid
- in_ready  output  1  block can accept a command
- opcode  input  opcode_e  ADD, SUB, MULT, DIV (from package)
- operand_a  input  WIDTH  signed first operand
- operand_b  input  WIDTH  signed second operand
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  signed result
- overflow  output  1  true result not representable in WIDTH bits
- div_by_zero  output  1  DIV with operand_b == 0

## Operation
- FSM states: IDLE, DIV_BUSY, HOLD.
  - IDLE: in_ready = !out_valid || out_ready.
  - DIV_BUSY and HOLD: in_ready = 0.
  - in_ready = 0 whenever rst is high.
- Accept = in_valid && in_ready. Operands and opcode are captured on the accepting edge.
- ADD/SUB: result = low WIDTH bits of the sum or difference. overflow = signed overflow (operand signs rule).
- MULT: full 2·WIDTH-bit signed product is formed. result = low WIDTH bits. overflow = 1 if the product is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- DIV, operand_b != 0:
  - IDLE → DIV_BUSY. Magnitudes are divided over WIDTH iterations, then sign is applied in the final cycle.
  - Quotient truncates toward zero.
  - MIN / −1: result = MIN, overflow = 1.
- DIV, operand_b == 0: no iteration. result = 0, div_by_zero = 1, overflow = 0, single-cycle latency.
- div_by_zero = 0 for all non-DIV ops. overflow = 0 unless a rule above sets it.
- Output register:
  - result and flags change only when a new result is loaded.
  - Held stable while out_valid && !out_ready.
  - out_valid clears on out_ready with no new load.
  - A simultaneous drain and new load keeps out_valid = 1 with new data.
- HOLD state: the division has finished but the output register is still occupied. The block waits for out_ready, then loads the result and returns to IDLE.

## Timing
- Reset values: out_valid = 0, result = 0, overflow = 0, div_by_zero = 0, state = IDLE. in_ready rises the first cycle after rst deasserts.
- Non-DIV and DIV-by-zero: accept at edge N → out_valid = 1 after edge N+1.
- DIV: accept at edge N → out_valid = 1 after edge N+WIDTH+1, provided the output is drained. in_ready rises in the cycle after the load.
- Throughput for non-DIV with out_ready held high: one command per cycle.
- Reset mid-DIV or during HOLD: the operation is aborted, no result is produced, and all outputs return to reset values on that edge.
- Operands change while busy: ignored. Only captured values are used.

## Structure
- Shared package holds:
  - opcode_e: 2-bit enum ADD = 0, SUB = 1, MULT = 2, DIV = 3.
  - alu_state_e: IDLE, DIV_BUSY, HOLD.
  - A localparam helper for WIDTH-bit signed MIN/MAX.
- Sub-module alu_div_iter contains the restoring divider. It has start/done handshake, WIDTH-bit unsigned magnitudes and a cycle counter. Sign handling and the FSM stay in alu_mc.

## Test plan (WIDTH = 8)
- ADD 100 + 50, out_ready = 1 → result 0x96 (−106), overflow = 1, out_valid one cycle after accept. SUB −128 − 1 → 0x7F, overflow = 1.
- MULT 12 × −11 → result 0x7C, overflow = 1. MULT −8 × 15 → 0x88 (−120), overflow = 0.
- DIV −7 / 2 → 0xFD (−3), out_valid 9 cycles after accept, in_ready = 0 throughout. DIV −128 / −1 → 0x80, overflow = 1.
- DIV 5 / 0 → result 0, div_by_zero = 1, latency 1, no busy period.
- Backpressure: with out_ready = 0 for 5 cycles after an ADD result, result and flags stay stable and in_ready = 0. A DIV started earlier waits in HOLD until drained. Back-to-back ADDs with out_ready = 1 give one result per cycle.
- Assert rst 3 cycles into a DIV → out_valid never rises for it, outputs go to 0, and the next command after reset completes normally.
